// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between the E stage and md_unit
interface md_unit_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mdout;

  modport master (output start, mdop, A, B, input busy, HI, LO, mdout);
  modport slave  (input start, mdop, A, B, output busy, HI, LO, mdout);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Results are computed at issue, parked in shadow registers and committed when the countdown ends.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] counter;
  logic [CW-1:0] opCycles;
  logic [31:0]   hiReg, loReg, sHi, sLo, resHi, resLo;
  logic [63:0]   prodS, prodU;
  logic [31:0]   aMag, bMag, qMag, rMag, uDivisor, uQ, uR;
  logic          divZero;

  assign divZero = (md.B == 32'd0);
  assign prodS = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign prodU = {32'd0, md.A} * {32'd0, md.B};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign aMag     = md.A[31] ? -md.A : md.A;
  assign bMag     = md.B[31] ? -md.B : (divZero ? 32'd1 : md.B);
  assign qMag     = aMag / bMag;
  assign rMag     = aMag % bMag;
  assign uDivisor = divZero ? 32'd1 : md.B;
  assign uQ       = md.A / uDivisor;
  assign uR       = md.A % uDivisor;

  always_comb begin
    resHi    = hiReg;
    resLo    = loReg;
    opCycles = CW'(DIV_CYCLES);
    case (md.mdop[1:0])
      2'd0: begin
        {resHi, resLo} = prodS;
        opCycles = CW'(MULT_CYCLES);
      end
      2'd1: begin
        {resHi, resLo} = prodU;
        opCycles = CW'(MULT_CYCLES);
      end
      2'd2: begin
        if (!divZero) begin
          resLo = (md.A[31] ^ md.B[31]) ? -qMag : qMag;
          resHi = md.A[31] ? -rMag : rMag;
        end
      end
      default: begin
        if (!divZero) begin
          resLo = uQ;
          resHi = uR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      sHi     <= '0;
      sLo     <= '0;
    end else if (state == IDLE) begin
      if (md.start) begin
        if (!md.mdop[2]) begin
          sHi     <= resHi;
          sLo     <= resLo;
          counter <= opCycles;
          state   <= RUN;
        end else if (md.mdop == 3'd4) begin
          hiReg <= md.A;
        end else if (md.mdop == 3'd5) begin
          loReg <= md.A;
        end
      end
    end else begin
      counter <= counter - 1'b1;
      if (counter == CW'(1)) begin
        hiReg <= sHi;
        loReg <= sLo;
        state <= IDLE;
      end
    end
  end

  assign md.busy = (state == RUN);
  assign md.HI   = hiReg;
  assign md.LO   = loReg;

  always_comb begin
    case (md.mdop)
      3'd6:    md.mdout = hiReg;
      3'd7:    md.mdout = loReg;
      default: md.mdout = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if mdIf ();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(mdIf.slave));

  int checks = 0;
  int failures = 0;
  logic [63:0] expQ[$];
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    logic signed [31:0] sa, sb, q, r;
    logic signed [63:0] p;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin
        p = sa * sb;
        return p;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Called at a negedge; presents one start cycle and returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b);
    mdIf.start = 1'b1;
    mdIf.mdop  = op;
    mdIf.A     = a;
    mdIf.B     = b;
    @(negedge clk);
    mdIf.start = 1'b0;
    mdIf.mdop  = 3'd0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, output int cnt, output bit held);
    logic [31:0] hi0, lo0;
    hi0 = mdIf.HI;
    lo0 = mdIf.LO;
    issue(op, a, b);
    cnt = 0;
    held = 1'b1;
    while (mdIf.busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (mdIf.HI !== hi0 || mdIf.LO !== lo0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mdIf.start = 1'b0;
    mdIf.mdop = 3'd6;
    mdIf.A = 32'd0;
    mdIf.B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (mdIf.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", mdIf.busy); end
    checks++; if (mdIf.HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=0", mdIf.HI); end
    checks++; if (mdIf.LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=0", mdIf.LO); end
    checks++; if (mdIf.mdout !== 32'd0) begin failures++; $display("FAIL reset_mdout got=%h want=0", mdIf.mdout); end
    mdIf.mdop = 3'd0;
  endtask

  task automatic test_op(input string name, input logic [2:0] op, input logic [31:0] a, b,
                         input logic [63:0] expVal, input int n);
    int cnt;
    bit held;
    logic [63:0] got;
    expQ.push_back(expVal);
    run_op(op, a, b, cnt, held);
    checks++; if (cnt != n) begin failures++; $display("FAIL %s_busy_len got=%0d want=%0d", name, cnt, n); end
    checks++; if (!held) begin failures++; $display("FAIL %s_hold got=changed want=stable", name); end
    got = expQ.pop_front();
    checks++;
    if ({mdIf.HI, mdIf.LO} !== got) begin
      failures++;
      $display("FAIL %s_result got=%h_%h want=%h_%h", name, mdIf.HI, mdIf.LO, got[63:32], got[31:0]);
    end
    mHi = got[63:32];
    mLo = got[31:0];
  endtask

  task automatic test_mthi_mf;
    bit sawBusy;
    sawBusy = 1'b0;
    mdIf.start = 1'b1; mdIf.mdop = 3'd4; mdIf.A = 32'h1234_5678;
    @(negedge clk);
    sawBusy |= mdIf.busy;
    mdIf.mdop = 3'd7;
    #1;
    checks++; if (mdIf.HI !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi got=%h want=12345678", mdIf.HI); end
    checks++; if (mdIf.mdout !== mLo) begin failures++; $display("FAIL mflo_mdout got=%h want=%h", mdIf.mdout, mLo); end
    @(negedge clk);
    sawBusy |= mdIf.busy;
    mdIf.mdop = 3'd6;
    #1;
    checks++; if (mdIf.mdout !== 32'h1234_5678) begin failures++; $display("FAIL mfhi_mdout got=%h want=12345678", mdIf.mdout); end
    mdIf.start = 1'b1; mdIf.mdop = 3'd5; mdIf.A = 32'hCAFE_F00D;
    @(negedge clk);
    sawBusy |= mdIf.busy;
    mdIf.start = 1'b0; mdIf.mdop = 3'd0;
    checks++; if (mdIf.LO !== 32'hCAFE_F00D) begin failures++; $display("FAIL mtlo_lo got=%h want=cafef00d", mdIf.LO); end
    checks++; if (sawBusy) begin failures++; $display("FAIL mtx_busy got=1 want=0"); end
    mHi = 32'h1234_5678;
    mLo = 32'hCAFE_F00D;
  endtask

  task automatic test_ignore_while_busy;
    int cnt;
    logic [63:0] got;
    expQ.push_back({32'd0, 32'd42});
    issue(3'd0, 32'd7, 32'd6);
    cnt = 0;
    while (mdIf.busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 1) begin mdIf.start = 1'b1; mdIf.mdop = 3'd5; mdIf.A = 32'h0000_DEAD; end
      else if (cnt == 2) begin mdIf.mdop = 3'd0; mdIf.A = 32'd9; mdIf.B = 32'd2; end
      else if (cnt == 3) begin mdIf.mdop = 3'd4; mdIf.A = 32'h0000_BEEF; end
      else begin mdIf.start = 1'b0; mdIf.mdop = 3'd0; end
      @(negedge clk);
    end
    mdIf.start = 1'b0;
    mdIf.mdop = 3'd0;
    checks++; if (cnt != 5) begin failures++; $display("FAIL ignore_busy_len got=%0d want=5", cnt); end
    got = expQ.pop_front();
    checks++;
    if ({mdIf.HI, mdIf.LO} !== got) begin
      failures++;
      $display("FAIL ignore_result got=%h_%h want=%h_%h", mdIf.HI, mdIf.LO, got[63:32], got[31:0]);
    end
    mHi = got[63:32];
    mLo = got[31:0];
  endtask

  task automatic test_reset_mid_run;
    bit bad;
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (mdIf.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", mdIf.busy); end
    checks++;
    if (mdIf.HI !== 32'd0 || mdIf.LO !== 32'd0) begin
      failures++; $display("FAIL midreset_hilo got=%h_%h want=0_0", mdIf.HI, mdIf.LO);
    end
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mdIf.busy !== 1'b0 || mdIf.HI !== 32'd0 || mdIf.LO !== 32'd0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL midreset_late_writeback got=nonzero want=0"); end
    mHi = 32'd0;
    mLo = 32'd0;
  endtask

  task automatic test_back_to_back;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom();
      b = (i == 5) ? 32'd0 : ((i == 6) ? 32'hFFFF_FFFF : $urandom());
      if (i == 6) begin op = 3'd2; a = 32'h8000_0000; end
      if (i == 5) op = 3'd2;
      test_op("b2b", op, a, b, model(op, a, b, mHi, mLo), (op[1] ? 10 : 5));
    end
  endtask

  initial begin
    mdIf.start = 1'b0;
    mdIf.mdop = 3'd0;
    mdIf.A = 32'd0;
    mdIf.B = 32'd0;
    test_reset();
    test_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5);
    test_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 5);
    test_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    test_op("divu_zero", 3'd3, 32'd7, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    test_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10);
    test_op("divu", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 10);
    test_mthi_mf();
    test_ignore_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers. It executes mult/multu/div/divu over a fixed multi-cycle latency and exports `busy`. The hazard unit consumes `busy` to stall any HI/LO-using instruction in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu.
- `DIV_CYCLES`, default 10: busy duration for div/divu.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: E-stage instruction is a valid md op this cycle; already gated by the pipeline (low during stall bubbles).
- `mdop` in 3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- `A` in 32: rs value (forwarded E-stage operand).
- `B` in 32: rt value (forwarded E-stage operand).
- `busy` out 1: an operation is in flight.
- `HI` out 32: architectural HI register.
- `LO` out 32: architectural LO register.
- `mdout` out 32: combinational read data. HI when `mdop`==6, LO when `mdop`==7, else 0.

## Operation
- Reset (synchronous, next edge while `reset`=1): HI=0, LO=0, `busy`=0, counter=0, shadow registers=0. Reset aborts any in-flight operation and discards its result.
- States: IDLE (counter==0, `busy`=0) and RUN (counter>0, `busy`=1).
- IDLE with `start`=1 and `mdop` 0..3:
  - Compute the 64-bit result combinationally from A and B.
  - Latch the result into shadow registers sHI and sLO.
  - Load the counter with MULT_CYCLES or DIV_CYCLES for the op.
  - Enter RUN.
- RUN:
  - The counter decrements each edge.
  - On the edge where the counter goes 1→0, copy sHI→HI and sLO→LO, and `busy` falls.
- mult: {HI,LO} = signed A × signed B.
- multu: {HI,LO} = unsigned A × unsigned B.
- div (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - Special case A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, both unsigned.
- Divide by zero (B=0, div or divu): full DIV_CYCLES busy, then HI/LO unchanged (sHI/sLO preloaded with the current HI/LO).
- mthi/mtlo with `start`=1 in IDLE: HI or LO ← A on the next edge. No busy period.
- mfhi/mflo: no state change; `mdout` reflects the current HI or LO.
- Any `start`=1 while `busy`=1 is ignored entirely. This covers every mdop, including mthi/mtlo. The hazard unit guarantees this does not occur; the block must still not corrupt state.
- `mdop` values 0..7 are exhaustive; no illegal encodings exist.

## Timing
- `start` sampled at edge T0:
  - `busy`=1 from T0 through edge T0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - `busy` is high for exactly N cycles.
  - HI/LO hold their new values after edge T0+N.
- `busy` is registered. It is low in the cycle `start` is first presented.
  - The hazard unit must stall on (`busy` or (`start` and mdop∈0..3)) && D-stage uses HI/LO.
- mfhi/mflo issued the cycle after `busy` falls reads the new result.
- mthi/mtlo: value visible on HI/LO one cycle after the `start` edge.
- `mdout` is purely combinational from `mdop`, HI and LO. It has zero latency and is forwarded through the E/M register like an ALU result.
- Back-to-back ops: a new `start` is accepted in the first cycle with `busy`=0, i.e. the cycle after the completing edge.
- `reset` asserted mid-RUN: at that edge, `busy`=0 and HI=LO=0. No late writeback follows.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3:
  - `busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO unchanged while busy.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div with A=−7 (0xFFFFFFF9), B=2:
  - `busy` high 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow with divu A=7, B=0: HI/LO retain the prior values after 10 busy cycles.
- mthi A=0x12345678, next cycle mflo, next cycle mfhi:
  - HI=0x12345678 after one edge.
  - `mdout` shows the LO value, then 0x12345678.
  - `busy` never asserted.
- Start mult, pulse `start` with mtlo A=0xDEAD during RUN: mtlo ignored; final LO equals the mult result.
- Start div, assert `reset` at cycle 4 of RUN:
  - Next cycle: `busy`=0, HI=LO=0.
  - HI/LO remain 0 through cycle 12.
